// File: rtl/obi_arbiter.sv
// N-to-1 OBI arbiter: selects one master for the shared slave port and routes each response back to the master that issued it.
// Define OBI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); the default build is round-robin.
module obi_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2,
    parameter int BE_W      = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS-1:0]        m_req,
    input  logic [N_MASTERS-1:0]        m_we,
    input  logic [N_MASTERS*BE_W-1:0]   m_be,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
    output logic [N_MASTERS-1:0]        m_gnt,
    output logic [N_MASTERS-1:0]        m_rvalid,
    output logic [N_MASTERS*DATA_W-1:0] m_rdata,
    output logic                        s_req,
    output logic                        s_we,
    output logic [BE_W-1:0]             s_be,
    output logic [ADDR_W-1:0]           s_addr,
    output logic [DATA_W-1:0]           s_wdata,
    input  logic                        s_gnt,
    input  logic                        s_rvalid,
    input  logic [DATA_W-1:0]           s_rdata,
    output logic                        err
);
    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic             lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUTST];
    logic [IDX_W-1:0] fifo_d [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] arb_sel, sel, idx;
    logic             found, push, pop;

`ifdef OBI_ARB_FIXED_PRIO_EN
    always_comb begin
        arb_sel = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx = IDX_W'(i);
            if (!found && m_req[idx]) begin
                arb_sel = idx;
                found   = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] last_q, last_d;

    // Search starts one past the last granted master so every requester gets a turn.
    always_comb begin
        arb_sel = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            idx = IDX_W'((int'(last_q) + i) % N_MASTERS);
            if (!found && m_req[idx]) begin
                arb_sel = idx;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (push) last_d = sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= IDX_W'(N_MASTERS - 1);
        else     last_q <= last_d;
    end
`endif

    always_comb begin
        sel   = (lock_vld_q && m_req[lock_idx_q]) ? lock_idx_q : arb_sel;
        // Eligibility ignores a same-cycle pop so s_rvalid never reaches s_req combinationally.
        s_req   = (|m_req) && (cnt_q < CNT_W'(MAX_OUTST));
        s_we    = m_we[sel];
        s_be    = m_be[int'(sel)*BE_W +: BE_W];
        s_addr  = m_addr[int'(sel)*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[int'(sel)*DATA_W +: DATA_W];
        push    = s_req && s_gnt;
        pop     = s_rvalid && (cnt_q != '0);
        m_gnt   = '0;
        m_rvalid = '0;
        m_gnt[sel] = push;
        m_rvalid[fifo_q[rd_ptr_q]] = pop;
    end

    always_comb begin
        lock_vld_d = s_req && !s_gnt;
        lock_idx_d = lock_vld_d ? sel : lock_idx_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q || (s_rvalid && (cnt_q == '0));
        if (push) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            fifo_q     <= fifo_d;
        end
    end

    assign m_rdata = {N_MASTERS{s_rdata}};
    assign err     = err_q;
endmodule

// File: tb/tb_obi_arbiter.sv
// Directed bench for obi_arbiter (2 masters, 2 outstanding): grants, lock, outstanding limit, routing, stray response, reset.
module tb_obi_arbiter;
    localparam int N = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_req = '0, m_we = '0, m_gnt, m_rvalid;
    logic [N*BW-1:0] m_be = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_wdata = '0, m_rdata;
    logic            s_req, s_we, s_gnt = 1'b0, s_rvalid = 1'b0, err;
    logic [BW-1:0]   s_be;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata, s_rdata = '0;

    int checks = 0;
    int errors = 0;

    obi_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(2)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are checked mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_g [4];
        logic [1:0] exp_r [3];
`ifdef OBI_ARB_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_r = '{2'b01, 2'b01, 2'b01};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_r = '{2'b01, 2'b10, 2'b01};
`endif
        #2;
        check("rst_gnt", m_gnt, 0);
        check("rst_rvalid", m_rvalid, 0);
        check("rst_sreq", s_req, 0);
        check("rst_err", err, 0);
        cyc(); cyc();
        rst = 1'b0;

        // Single master read
        cyc();
        m_req = 2'b10; m_addr[63:32] = 32'h0000_0100; m_be[7:4] = 4'hF; s_gnt = 1'b1;
        #1;
        check("single_sreq", s_req, 1);
        check("single_gnt", m_gnt, 2'b10);
        check("single_addr", s_addr, 32'h0000_0100);
        check("single_be", s_be, 4'hF);
        cyc();
        m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
        #1;
        check("single_rvalid", m_rvalid, 2'b10);
        check("single_rdata", m_rdata[63:32], 32'hDEADBEEF);
        cyc();
        s_rvalid = 1'b0;

        // Contention: both masters requesting, slave grants every cycle
        m_req = 2'b11; s_gnt = 1'b1; m_we = 2'b01; m_addr[31:0] = 32'h0000_0A00;
        for (int k = 0; k < 4; k++) begin
            s_rvalid = (k > 0);
            #1;
            check($sformatf("cont_gnt%0d", k), m_gnt, exp_g[k]);
            if (k > 0) check($sformatf("cont_rv%0d", k), m_rvalid, exp_r[k-1]);
            cyc();
        end
        m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1; m_we = 2'b00;
        #1;
        check("cont_drain", m_rvalid, exp_g[3]);
        cyc();
        s_rvalid = 1'b0;

        // Lock: master 1 stalled by the slave while master 0 joins
        m_req = 2'b10; m_addr[63:32] = 32'h0000_0200; m_addr[31:0] = 32'h0000_0300;
        #1;
        check("lock_a_addr", s_addr, 32'h0000_0200);
        check("lock_a_gnt", m_gnt, 0);
        cyc();
        m_req = 2'b11;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("lock_hold%0d", k), s_addr, 32'h0000_0200);
            cyc();
        end
        s_gnt = 1'b1;
        #1;
        check("lock_gnt1", m_gnt, 2'b10);
        cyc();
        m_req = 2'b01;
        #1;
        check("lock_gnt0", m_gnt, 2'b01);
        cyc();

        // Outstanding limit: two pending (1 then 0)
        #1;
        check("full_sreq", s_req, 0);
        check("full_gnt", m_gnt, 0);
        cyc();
        s_rvalid = 1'b1;
        #1;
        check("full_pop_sreq", s_req, 0);
        check("full_pop_rv", m_rvalid, 2'b10);
        cyc();
        s_rvalid = 1'b0;
        #1;
        check("full_reopen", s_req, 1);
        check("full_reopen_gnt", m_gnt, 2'b01);
        cyc();
        m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h1111_1111;
        #1;
        check("full_rv_a", m_rvalid, 2'b01);
        check("full_rd_a", m_rdata[31:0], 32'h1111_1111);
        cyc();
        s_rdata = 32'h2222_2222;
        #1;
        check("full_rv_b", m_rvalid, 2'b01);
        cyc();
        s_rvalid = 1'b0;
        #1;
        check("full_cnt0", dut.cnt_q, 0);

        // Interleave: grants 0,1,0 with responses A,B,C
        m_req = 2'b01; s_gnt = 1'b1;
        #1;
        check("il_g0", m_gnt, 2'b01);
        cyc();
        m_req = 2'b10;
        #1;
        check("il_g1", m_gnt, 2'b10);
        cyc();
        m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hAAAA_0001;
        #1;
        check("il_rv_a", m_rvalid, 2'b01);
        check("il_rd_a", m_rdata[31:0], 32'hAAAA_0001);
        cyc();
        m_req = 2'b01; s_gnt = 1'b1; s_rdata = 32'hBBBB_0002;
        #1;
        check("il_rv_b", m_rvalid, 2'b10);
        check("il_rd_b", m_rdata[63:32], 32'hBBBB_0002);
        check("il_g2", m_gnt, 2'b01);
        cyc();
        m_req = 2'b00; s_gnt = 1'b0; s_rdata = 32'hCCCC_0003;
        #1;
        check("il_rv_c", m_rvalid, 2'b01);
        check("il_rd_c", m_rdata[31:0], 32'hCCCC_0003);
        cyc();
        s_rvalid = 1'b0;
        #1;
        check("il_cnt0", dut.cnt_q, 0);
        check("il_err", err, 0);

        // Stray response
        s_rvalid = 1'b1;
        #1;
        check("stray_rv", m_rvalid, 0);
        cyc();
        s_rvalid = 1'b0;
        #1;
        check("stray_err", err, 1);

        // Leave one transaction pending, then reset asynchronously mid-cycle
        m_req = 2'b01; s_gnt = 1'b1;
        cyc();
        m_req = 2'b00; s_gnt = 1'b0;
        #1;
        check("pre_rst_cnt", dut.cnt_q, 1);
        rst = 1'b1;
        #1;
        check("arst_err", err, 0);
        check("arst_cnt", dut.cnt_q, 0);
        cyc();
        rst = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/obi_arbiter.md
# obi_arbiter

Parametrised N-to-1 arbiter for the core's OBI-style memory interface (req/gnt address phase, rvalid response phase). It merges N master ports onto one slave port: the instruction port, the data port and any future DMA or debug master. It tracks outstanding transactions so each response returns to the master that issued it. The block sits between `cv32e40p_top` and `bus`, replacing the dedicated instr/data paths in `bus` with a single shared slave port.

## Interface
- `N_MASTERS`, 2: number of master ports, 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width, multiple of 8; `BE_W = DATA_W/8`.
- `MAX_OUTST`, 2: maximum outstanding granted-but-unanswered transactions, 1..8.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m_req` in N_MASTERS: per-master request.
- `m_we` in N_MASTERS: per-master write enable.
- `m_be` in N_MASTERS*BE_W: byte enables; master i at `[i*BE_W +: BE_W]`.
- `m_addr` in N_MASTERS*ADDR_W: addresses, packed the same way.
- `m_wdata` in N_MASTERS*DATA_W: write data.
- `m_gnt` out N_MASTERS: grant, one-hot or zero.
- `m_rvalid` out N_MASTERS: response valid, one-hot or zero.
- `m_rdata` out N_MASTERS*DATA_W: read data; the same `s_rdata` is broadcast to every slice.
- `s_req`, `s_we`, `s_be`, `s_addr`, `s_wdata` out: slave address phase.
- `s_gnt`, `s_rvalid` in 1; `s_rdata` in DATA_W: slave responses.
- `err` out 1: sticky flag for an unexpected `s_rvalid`. Cleared only by `rst`.

## Operation
- Selection: among asserted `m_req`, pick one master `sel`. The slave address-phase outputs mux from `sel`.
- Eligibility: `s_req = |m_req & (cnt < MAX_OUTST)`. Here `cnt` is the ID FIFO occupancy. A same-cycle pop is not counted, which avoids a combinational path from `s_rvalid` to `s_req`.
- Grant: `m_gnt[sel] = s_req & s_gnt`. All other `m_gnt` bits are 0.
- Lock: while `s_req & ~s_gnt`, `sel` is frozen in the `lock` register. The slave sees stable signals until `gnt`. A higher-priority request arriving meanwhile is not serviced first.
  - If the locked master drops `m_req` (OBI violation), the lock clears and selection re-arbitrates in the same cycle.
- Round-robin: the `last` pointer holds the index of the last granted master. The search starts at `last+1` modulo N_MASTERS. `last` updates only on a grant.
- ID FIFO: depth MAX_OUTST, entries are `$clog2(N_MASTERS)` bits wide.
  - Each grant pushes `sel`.
  - Each `s_rvalid` pops.
  - `m_rvalid[head] = s_rvalid & (cnt != 0)`.
  - Simultaneous push and pop leaves `cnt` unchanged. Pointers wrap modulo MAX_OUTST.
- Stray response: `s_rvalid` with `cnt == 0` is dropped, no `m_rvalid` asserts, and `err` sets to 1.
- Writes also produce an `s_rvalid` and are routed the same way.

## Timing
- Reset values:
  - `m_gnt = 0`, `m_rvalid = 0`, `s_req = 0` (no master inputs are asserted during reset), `err = 0`.
  - `cnt = 0`, FIFO pointers 0, `last = N_MASTERS-1`, so master 0 is searched first.
  - Lock cleared.
- Address path is combinational: `m_req` to `s_req` and `s_gnt` to `m_gnt` in 0 cycles. The grant is visible in the same cycle as the request if the slave grants.
- Response path is combinational: `s_rvalid` to `m_rvalid` in 0 cycles.
- FIFO full (`cnt == MAX_OUTST`): `s_req` is held low. It reasserts the cycle after the pop registers.
- Reset mid-transaction: all tracking is lost. The slave must be reset by the same `rst`.

## Configuration
- `OBI_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins (master 0 = instruction fetch). The `last` register is not built. Lock behaviour is unchanged.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Single master: master 1 read at 0x0000_0100, slave grants the same cycle and returns `rvalid` with `s_rdata=0xDEADBEEF` 1 cycle later -> `m_gnt=2'b10` in cycle 0, `m_rvalid=2'b10` and master 1 `rdata=0xDEADBEEF` in cycle 1.
- Contention: masters 0 and 1 both hold `m_req` for 4 grants, with `s_gnt=1` every cycle -> round-robin grant order 0,1,0,1. With `OBI_ARB_FIXED_PRIO_EN` the order is 0,0,0,0.
- Lock: master 1 is selected and `s_gnt=0` for 3 cycles while master 0 raises `m_req` -> `s_addr` stays master 1's address and the grant goes to master 1 first.
- Outstanding limit: MAX_OUTST=2, slave grants 2 with no `rvalid` -> third `s_req=0`. After one `s_rvalid`, `s_req=1` on the next cycle. Responses are routed in grant order.
- Interleave: grants to masters 0,1,0 with responses A,B,C -> `m_rvalid` routing 0,1,0 with matching data, `cnt` returns to 0.
- Stray response and reset: `s_rvalid` with `cnt=0` -> no `m_rvalid`, `err=1`. Asserting `rst` then clears `err` and `cnt` asynchronously.
